// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
// 8N1-style UART receiver clocked by the UART PLL output. Each bit period is
// split into 16 oversample ticks. The bit value is the majority of three
// samples taken around mid-bit, so a single noisy sample cannot flip a bit.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | line idle, waiting for a 1->0 edge on the synchronized rxd
//   S_START | confirming the start bit; a high vote means it was a glitch
//   S_DATA  | shifting in DATA_BITS data bits, LSB first
//   S_STOP  | checking the stop bit and issuing exactly one result strobe
module uart_rx_oversampled #(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD        = 9600,
    parameter int DATA_BITS   = 8,
    parameter int DIV         = (CLK_FREQ_HZ + 8 * BAUD) / (16 * BAUD)
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 pll_locked,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic                 rxd_prev_q, rxd_prev_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [3:0]           ts_q, ts_d;
    logic [1:0]           samp_q, samp_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 break_det_q, break_det_d;

    logic                 rxd_s;
    logic                 tick;
    logic [3:0]           ts_nxt;
    logic                 vote;
    logic                 at_vote;
    logic                 at_wrap;
    logic                 run;

    // Lock loss behaves exactly like reset so a half-received frame is dropped.
    assign run = rst & pll_locked;

    // Synchronizer, oversample tick and the majority vote of the three mid-bit samples.
    always_comb begin
        sync_d     = {sync_q[0], rxd};
        rxd_s      = sync_q[1];
        rxd_prev_d = rxd_s;
        tick       = (div_q == DIV_W'(DIV - 1));
        ts_nxt     = ts_q + 4'd1;
        // "At ts=k" is the tick that advances ts to k, i.e. k*DIV cycles into the bit.
        at_vote    = tick && (ts_nxt == 4'd9);
        at_wrap    = tick && (ts_nxt == 4'd0);
        vote       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);
    end

    // Next-state and datapath updates; result strobes are registered one-cycle pulses.
    always_comb begin
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        ts_d        = tick ? ts_nxt : ts_q;
        samp_d      = samp_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        break_det_d = 1'b0;

        if (tick && (ts_nxt == 4'd7)) begin
            samp_d[0] = rxd_s;
        end
        if (tick && (ts_nxt == 4'd8)) begin
            samp_d[1] = rxd_s;
        end

        case (state_q)
            S_IDLE: begin
                // Divider and tick index stay cleared so the first tick lands
                // exactly DIV cycles after the start edge.
                div_d = '0;
                ts_d  = 4'd0;
                if (!rxd_s && rxd_prev_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (at_vote && vote) begin
                    state_d = S_IDLE;
                end else if (at_wrap) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (at_vote) begin
                    shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                end
                if (at_wrap) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Leave at mid stop bit so a start edge right after it is not missed.
                if (at_vote) begin
                    state_d = S_IDLE;
                    if (vote) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        break_det_d = (shreg_q == '0);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset, also forced while the PLL is unlocked.
    always_ff @(posedge refclk) begin
        if (!run) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b11;
            rxd_prev_q  <= 1'b1;
            div_q       <= '0;
            ts_q        <= 4'd0;
            samp_q      <= 2'b11;
            bit_idx_q   <= 3'd0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            break_det_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            rxd_prev_q  <= rxd_prev_d;
            div_q       <= div_d;
            ts_q        <= ts_d;
            samp_q      <= samp_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            break_det_q <= break_det_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign break_det = break_det_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled. The receiver runs with a fast baud rate
// (DIV = 4 refclk cycles per tick) so every scenario fits in a short run.
module tb_uart_rx_oversampled;

    localparam int DB     = 8;
    localparam int DIV_TB = 4;            // (25e6 + 8*400e3) / (16*400e3) = 4.41 -> 4
    localparam int BIT    = 16 * DIV_TB;  // 64 refclk cycles per bit
    localparam int FRAME  = 10 * BIT;
    localparam int K_VAL  = 1;
    localparam int K_FE   = 2;
    localparam int K_BRK  = 3;

    typedef struct {
        int          kind;
        logic [7:0]  data;
        int          t;
    } ev_t;

    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       pll_locked = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       break_det;
    logic       busy;

    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         n_valid = 0;
    int         n_fe = 0;
    int         n_brk = 0;
    logic [7:0] model_data = 8'h00;
    ev_t        exp_q[$];
    ev_t        cur_ev;
    int         vt[$];
    int         t_start;
    int         kind_act;

    uart_rx_oversampled #(
        .CLK_FREQ_HZ(25000000),
        .BAUD       (400000),
        .DATA_BITS  (DB)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .break_det (break_det),
        .busy      (busy)
    );

    always #20 refclk = ~refclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_win(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Outcome of a frame from the line levels alone: good stop -> byte, bad stop -> error/break.
    // The strobe lands at the stop bit's mid-point as counted by the receiver,
    // 3 cycles of sync/edge latency after the start edge is driven.
    task automatic expect_frame(input logic [7:0] b, input logic stop_lvl, input int t0);
        ev_t e;
        e.kind = stop_lvl ? K_VAL : ((b == 8'h00) ? K_BRK : K_FE);
        e.data = b;
        e.t    = t0 + 3 + ((1 + DB) * 16 + 9) * DIV_TB;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge refclk);
    endtask

    // Drives one frame starting at the current negedge; abort_at >= 0 pulls rst
    // low from that bit slot to the end of the frame.
    task automatic send(input logic [7:0] b, input int bl, input logic stop_lvl,
                        input bit expect_rx, input int abort_at);
        logic lvl;
        t_start = cyc;
        if (expect_rx) expect_frame(b, stop_lvl, cyc);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) lvl = 1'b0;
            else if (i == 9) lvl = stop_lvl;
            else lvl = b[i-1];
            if (abort_at >= 0 && i == abort_at) rst = 1'b0;
            rxd = lvl;
            repeat (bl) @(negedge refclk);
        end
        if (abort_at >= 0) rst = 1'b1;
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after each rising edge.
    always @(posedge refclk) begin
        #1;
        cyc = cyc + 1;
        if (!rst || !pll_locked) begin
            model_data = 8'h00;
            check("busy_gated", {31'd0, busy}, 32'd0);
            check("strobe_gated", {29'd0, rx_valid, frame_err, break_det}, 32'd0);
        end
        check("valid_fe_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
        check("break_implies_fe", {31'd0, break_det & ~frame_err}, 32'd0);
        if (rx_valid || frame_err || break_det) begin
            kind_act = break_det ? K_BRK : (frame_err ? K_FE : K_VAL);
            if (rx_valid) begin
                n_valid++;
                vt.push_back(cyc);
            end
            if (frame_err) n_fe++;
            if (break_det) n_brk++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", kind_act, 0);
            end else begin
                cur_ev = exp_q.pop_front();
                check("strobe_kind", kind_act, cur_ev.kind);
                check_win("strobe_time", cyc, cur_ev.t - 1, cur_ev.t + 1);
                if (cur_ev.kind == K_VAL) model_data = cur_ev.data;
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].t + 1) begin
            cur_ev = exp_q.pop_front();
            check_win("strobe_missing", cyc, cur_ev.t - 1, cur_ev.t + 1);
            if (cur_ev.kind == K_VAL) model_data = cur_ev.data;
        end
        check("rx_data", {24'd0, rx_data}, {24'd0, model_data});
    end

    int t_first;

    initial begin
        // Reset, then hold the PLL unlocked while a frame goes by.
        repeat (3) @(negedge refclk);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        pll_locked = 1'b0;
        send(8'h41, BIT, 1'b1, 1'b0, -1);
        idle(20);
        pll_locked = 1'b1;
        idle(20);
        send(8'h41, BIT, 1'b1, 1'b1, -1);
        t_first = t_start;
        idle(20);
        check("data_0x41", {24'd0, rx_data}, 32'h41);
        check_win("latency_0x41", (vt.size() > 0) ? vt[vt.size()-1] - t_first : -1, 614, 616);

        // Back-to-back frames with no idle gap.
        send(8'h55, BIT, 1'b1, 1'b1, -1);
        send(8'hA3, BIT, 1'b1, 1'b1, -1);
        idle(20);
        check("data_0xA3", {24'd0, rx_data}, 32'hA3);
        check_win("b2b_spacing", (vt.size() >= 2) ? vt[vt.size()-1] - vt[vt.size()-2] : -1, 639, 641);

        // Glitch: 3 ticks low must be rejected at the start-bit vote.
        t_first = cyc;
        rxd = 1'b0;
        repeat (3 * DIV_TB) @(negedge refclk);
        rxd = 1'b1;
        check("glitch_busy_mid", {31'd0, busy}, 32'd1);
        repeat (3 + 9 * DIV_TB - 3 * DIV_TB) @(negedge refclk);
        check("glitch_busy_cleared", {31'd0, busy}, 32'd0);
        idle(60);

        // Framing error: rx_data must keep the last good byte.
        send(8'h3C, BIT, 1'b0, 1'b1, -1);
        idle(30);
        check("fe_data_kept", {24'd0, rx_data}, 32'hA3);

        // Break: line held low for two frame times.
        expect_frame(8'h00, 1'b0, cyc);
        rxd = 1'b0;
        repeat (2 * FRAME) @(negedge refclk);
        check("break_no_retrigger", {31'd0, busy}, 32'd0);
        idle(100);
        send(8'h7E, BIT, 1'b1, 1'b1, -1);
        idle(20);
        check("data_0x7E", {24'd0, rx_data}, 32'h7E);

        // Baud tolerance: -3% and +3% bit periods.
        send(8'hC9, 62, 1'b1, 1'b1, -1);
        idle(20);
        check("data_fast", {24'd0, rx_data}, 32'hC9);
        send(8'hC9, 66, 1'b1, 1'b1, -1);
        idle(20);
        check("data_slow", {24'd0, rx_data}, 32'hC9);

        // Reset during data bit 4: frame dropped, rx_data back to 0.
        send(8'hC9, BIT, 1'b1, 1'b0, 5);
        idle(FRAME);
        check("abort_data_cleared", {24'd0, rx_data}, 32'h00);

        idle(50);
        check("pending_events", exp_q.size(), 32'd0);
        check("count_valid", n_valid, 32'd6);
        check("count_frame_err", n_fe, 32'd2);
        check("count_break", n_brk, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
